// File: rtl/arb2_merge.sv
// Two-input packet merge: a round-robin arbiter that locks onto a port for a whole
// packet and feeds a single registered output stage (one beat per cycle at full rate).
module arb2_merge #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in0_valid,
  input  logic [DW-1:0] in0_data,
  input  logic          in0_last,
  output logic          in0_ready,
  input  logic          in1_valid,
  input  logic [DW-1:0] in1_data,
  input  logic          in1_last,
  output logic          in1_ready,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_src,
  input  logic          out_ready,
  output logic [1:0]    fsm_state
);

  // Handshake: a beat moves on any port exactly in a cycle where its valid and ready
  // are both 1. Ready is only raised for the granted port while it is valid and the
  // output register is empty or draining in the same cycle.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t        state;
  logic          last_grant;
  logic          ld;
  logic          grant_any;
  logic          grant_sel;
  logic          accept;
  logic          beat_last;
  logic [DW-1:0] beat_data;

  always_comb begin
    grant_any = 1'b0;
    grant_sel = 1'b0;
    case (state)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          grant_any = 1'b1;
          grant_sel = ~last_grant;
        end else if (in0_valid) begin
          grant_any = 1'b1;
          grant_sel = 1'b0;
        end else if (in1_valid) begin
          grant_any = 1'b1;
          grant_sel = 1'b1;
        end
      end
      LOCK0: begin
        grant_any = 1'b1;
        grant_sel = 1'b0;
      end
      LOCK1: begin
        grant_any = 1'b1;
        grant_sel = 1'b1;
      end
      default: begin
        grant_any = 1'b0;
        grant_sel = 1'b0;
      end
    endcase
  end

  assign ld        = !out_valid || out_ready;
  assign in0_ready = !rst && ld && grant_any && !grant_sel && in0_valid;
  assign in1_ready = !rst && ld && grant_any &&  grant_sel && in1_valid;
  assign accept    = in0_ready || in1_ready;
  assign beat_data = grant_sel ? in1_data : in0_data;
  assign beat_last = grant_sel ? in1_last : in0_last;
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_last   <= 1'b0;
      out_src    <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_data   <= beat_data;
      out_last   <= beat_last;
      out_src    <= grant_sel;
      last_grant <= grant_sel;
      // A single-beat packet never locks; a continuing packet pins the grant.
      if (beat_last) state <= IDLE;
      else           state <= grant_sel ? LOCK1 : LOCK0;
    end else if (ld) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_arb2_merge.sv
// Bench for arb2_merge: directed scenarios then random traffic, all checked against a
// packet-level arbitration model and a one-deep expected-output queue.
module tb_arb2_merge;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          in0_valid, in0_last, in0_ready;
  logic [DW-1:0] in0_data;
  logic          in1_valid, in1_last, in1_ready;
  logic [DW-1:0] in1_data;
  logic          out_valid, out_last, out_src, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    fsm_state;

  int checks   = 0;
  int failures = 0;

  // Driver side: per-port pending beats {last, data}; en* gates valid per cycle.
  logic [DW:0]   p0_q[$];
  logic [DW:0]   p1_q[$];
  logic          en0, en1;
  // Model side: beats expected in the output register {src, last, data}.
  logic [DW+1:0] exp_q[$];
  int            owner;       // port whose packet is in progress, -1 if none
  int            last_win;    // port that won the most recent accepted beat

  always #5 clk = ~clk;

  arb2_merge #(.DW(DW)) dut (
    .clk(clk), .rst(rst),
    .in0_valid(in0_valid), .in0_data(in0_data), .in0_last(in0_last), .in0_ready(in0_ready),
    .in1_valid(in1_valid), .in1_data(in1_data), .in1_last(in1_last), .in1_ready(in1_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_src(out_src),
    .out_ready(out_ready), .fsm_state(fsm_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check at the falling edge, advance the model.
  task automatic cycle();
    logic          v0, v1, r0, r1, ld_m;
    int            pick;
    logic [DW+1:0] head;
    v0 = en0 && (p0_q.size() > 0);
    v1 = en1 && (p1_q.size() > 0);
    in0_valid = v0;
    in1_valid = v1;
    if (v0) {in0_last, in0_data} = p0_q[0];
    else    {in0_last, in0_data} = (DW+1)'($urandom);
    if (v1) {in1_last, in1_data} = p1_q[0];
    else    {in1_last, in1_data} = (DW+1)'($urandom);
    @(negedge clk);
    check("both_ready", {31'd0, in0_ready & in1_ready}, 32'd0);
    if (rst) begin
      check("rst_ready0", {31'd0, in0_ready}, 32'd0);
      check("rst_ready1", {31'd0, in1_ready}, 32'd0);
      exp_q.delete();
      owner    = -1;
      last_win = 1;
    end else begin
      ld_m = (exp_q.size() == 0) || out_ready;
      if (owner >= 0)    pick = owner;
      else if (v0 && v1) pick = 1 - last_win;
      else if (v0)       pick = 0;
      else if (v1)       pick = 1;
      else               pick = -1;
      r0 = ld_m && (pick == 0) && v0;
      r1 = ld_m && (pick == 1) && v1;
      check("in0_ready", {31'd0, in0_ready}, {31'd0, r0});
      check("in1_ready", {31'd0, in1_ready}, {31'd0, r1});
      check("out_valid", {31'd0, out_valid}, {31'd0, exp_q.size() > 0});
      if (exp_q.size() > 0) begin
        head = exp_q[0];
        check("out_data", {24'd0, out_data}, {24'd0, head[DW-1:0]});
        check("out_last", {31'd0, out_last}, {31'd0, head[DW]});
        check("out_src",  {31'd0, out_src},  {31'd0, head[DW+1]});
        if (out_ready) void'(exp_q.pop_front());
      end
      if (r0) begin
        exp_q.push_back({1'b0, p0_q[0]});
        owner    = p0_q[0][DW] ? -1 : 0;
        last_win = 0;
        void'(p0_q.pop_front());
      end else if (r1) begin
        exp_q.push_back({1'b1, p1_q[0]});
        owner    = p1_q[0][DW] ? -1 : 1;
        last_win = 1;
        void'(p1_q.pop_front());
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1; en0 = 1'b0; en1 = 1'b0; out_ready = 1'b0;
    in0_valid = 1'b0; in1_valid = 1'b0;
    in0_data = '0; in1_data = '0; in0_last = 1'b0; in1_last = 1'b0;
    owner = -1; last_win = 1;
    @(posedge clk); #1;
    run(2);
    rst = 1'b0;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_data",  {24'd0, out_data},  32'd0);
    check("reset_out_last",  {31'd0, out_last},  32'd0);
    check("reset_out_src",   {31'd0, out_src},   32'd0);
    check("reset_state",     {30'd0, fsm_state}, 32'd0);

    // Tie alternation: 0x11 / 0x22 single-beat packets on both ports.
    p0_q = '{{1'b1, 8'h11}, {1'b1, 8'h11}};
    p1_q = '{{1'b1, 8'h22}, {1'b1, 8'h22}};
    en0 = 1'b1; en1 = 1'b1; out_ready = 1'b1;
    run(4);

    // Port 0 three-beat packet must not be interleaved with port 1.
    p0_q = '{{1'b0, 8'hA0}, {1'b0, 8'hA1}, {1'b1, 8'hA2}};
    p1_q = '{{1'b1, 8'hB0}};
    run(6);

    // Backpressure: output stalled 3 cycles, then released.
    p0_q = '{{1'b1, 8'h31}, {1'b1, 8'h32}, {1'b1, 8'h33}};
    p1_q = '{{1'b1, 8'h41}, {1'b1, 8'h42}, {1'b1, 8'h43}};
    run(1);
    out_ready = 1'b0;
    run(3);
    out_ready = 1'b1;
    run(8);

    // Lone port 1 beat.
    p1_q = '{{1'b1, 8'h5A}};
    run(3);

    // Reset mid-packet on port 1 while port 0 waits.
    p0_q = '{{1'b1, 8'hD0}};
    p1_q = '{{1'b0, 8'hC0}, {1'b0, 8'hC1}, {1'b1, 8'hC2}};
    en0 = 1'b0;
    run(1);
    en0 = 1'b1;
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    p1_q.delete();
    p1_q = '{{1'b1, 8'hE0}};
    run(4);

    // Random traffic with valid gaps and output backpressure.
    for (int i = 0; i < 600; i++) begin
      if (p0_q.size() == 0) begin
        int n0 = $urandom_range(1, 4);
        for (int k = 0; k < n0; k++) p0_q.push_back({k == n0 - 1, DW'($urandom)});
      end
      if (p1_q.size() == 0) begin
        int n1 = $urandom_range(1, 4);
        for (int k = 0; k < n1; k++) p1_q.push_back({k == n1 - 1, DW'($urandom)});
      end
      en0 = ($urandom_range(0, 3) != 0);
      en1 = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end

    // Drain: no new input, consumer always ready.
    en0 = 1'b0; en1 = 1'b0; out_ready = 1'b1;
    run(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb2_merge.md
ARB2_MERGE -- requirements
Module: arb2_merge

Interface
REQ-001 The block SHALL have parameter DW, default 8, meaning the data width of each input and of the output.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 in0_valid  input  1  port 0 beat available.
REQ-005 in0_data  input  DW  port 0 beat data.
REQ-006 in0_last  input  1  port 0 beat is final beat of its packet.
REQ-007 in0_ready  output  1  port 0 beat accepted this cycle.
REQ-008 in1_valid, in1_data, in1_last, in1_ready SHALL mirror REQ-004..REQ-007 for port 1.
REQ-009 out_valid  output  1  output register holds a beat.
REQ-010 out_data  output  DW  registered beat data.
REQ-011 out_last  output  1  registered last flag.
REQ-012 out_src  output  1  source port of the registered beat; serves as select s of a downstream 2:1 mux.
REQ-013 out_ready  input  1  consumer accepts the beat this cycle.

Function
REQ-014 A transfer on port i SHALL occur in a cycle where ini_valid and ini_ready are both 1; the output transfer occurs in a cycle where out_valid and out_ready are both 1.
REQ-015 Load enable: ld = (out_valid == 0) or out_ready.
REQ-016 At most one of in0_ready/in1_ready SHALL be 1 in any cycle; ini_ready = ld and grant==i and ini_valid, so ready never asserts without the matching valid.
REQ-017 The block SHALL be a state machine with states IDLE, LOCK0, LOCK1.
REQ-018 IDLE grant: only one port valid -> that port; both valid -> port other than last_grant; neither -> no grant.
REQ-019 LOCK0 grant SHALL be port 0 only; LOCK1 grant SHALL be port 1 only, regardless of the other port's valid.
REQ-020 Transitions: on an accepted beat with last=0 from port i, the next state SHALL be LOCKi; on an accepted beat with last=1, the next state SHALL be IDLE; with no accepted beat, the state is held.
REQ-021 last_grant SHALL update to i on every accepted beat from port i.
REQ-022 On an accepted beat, out_data/out_last/out_src SHALL load that beat's data/last/port at the next edge, and out_valid SHALL become 1; latency is exactly one cycle from input transfer to out_valid.
REQ-023 When ld=1 and no input beat is accepted, out_valid SHALL become 0; out_data/out_last/out_src hold their values.
REQ-024 When out_valid=1 and out_ready=0, all output registers SHALL hold and both in*_ready SHALL be 0.
REQ-025 Simultaneous output drain and input accept in one cycle SHALL sustain throughput of one beat per cycle with no bubble.
REQ-026 A packet in progress SHALL never be interleaved with beats of the other port; a single-beat packet (last=1) SHALL not enter a LOCK state.
REQ-027 Input data while ini_ready=0 SHALL not affect any state.

Reset
REQ-028 With rst=1 at a rising edge, the next state SHALL be: state IDLE, last_grant=1 (port 0 wins the first tie), out_valid=0, out_data=0, out_last=0, out_src=0.
REQ-029 While rst=1, in0_ready and in1_ready SHALL be 0.
REQ-030 Reset asserted mid-packet SHALL abandon the lock and the held beat; the first post-reset arbitration follows REQ-018 from IDLE.

Verification
REQ-031 Reset then both ports valid with last=1, data 0x11/0x22, out_ready=1 for 4 cycles -> out_src sequence 0,1,0,1; out_data 0x11,0x22,0x11,0x22; out_valid=1 every cycle after the first.
REQ-032 Port 0 sends 3-beat packet 0xA0,0xA1,0xA2 (last on third) while port 1 is constantly valid with 0xB0 -> outputs 0xA0,0xA1,0xA2 then 0xB0; in1_ready=0 during the port 0 packet.
REQ-033 Output held with out_ready=0 for 3 cycles while both ports are valid -> out_data stable, in0_ready=in1_ready=0; on release, one beat per cycle with no bubble.
REQ-034 Only port 1 valid, 0x5A, last=1 -> in1_ready=1 immediately; out_src=1, out_data=0x5A one cycle later; in0_ready stays 0.
REQ-035 rst asserted after beat 1 of a 3-beat port 1 packet, with port 0 valid -> out_valid=0 the cycle after reset; after reset release, port 0 granted first (last_grant=1).
REQ-036 Bench SHALL check every cycle that in0_ready and in1_ready are never both 1, and that no output beat is lost or duplicated against a scoreboard.
